// File: rtl/rtio_sched_pkg.sv
// Shared types for the timed-event scheduler: FSM states, default widths, event record.
package rtio_sched_pkg;

    localparam int TS_WIDTH_DEF   = 64;
    localparam int DATA_WIDTH_DEF = 64;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ISSUE
    } state_t;

    typedef struct packed {
        logic [TS_WIDTH_DEF-1:0]   ts;
        logic [DATA_WIDTH_DEF-1:0] data;
    } event_t;

endpackage

// File: rtl/rtio_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous reset and flush.
// Latency: a pushed word is readable the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty.
module rtio_sync_fifo #(
    parameter int WIDTH     = 128,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_dat,
    input  logic                 pop,
    output logic [WIDTH-1:0]     pop_dat,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_WIDTH'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rtio_event_scheduler.sv
// Timed-event scheduler: buffers (timestamp, data) events and releases each when counter reaches it.
// Latency: m_valid rises the cycle after counter >= head timestamp; at most one event per 2 cycles.
// Backpressure: s_ready = !fifo_full; ISSUE holds outputs until m_ready. RTIO_SCHED_LATE_DROP_EN drops late events.
module rtio_event_scheduler
    import rtio_sched_pkg::*;
#(
    parameter int TS_WIDTH   = TS_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [TS_WIDTH-1:0]   counter,
    input  logic                  flush,
    input  logic                  s_valid,
    input  logic [TS_WIDTH-1:0]   s_timestamp,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [TS_WIDTH-1:0]   m_timestamp,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  fifo_count,
    output logic                  underflow,
    input  logic                  underflow_clr
);

    typedef struct packed {
        logic [TS_WIDTH-1:0]   ts;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                fifo_wr;
    entry_t                fifo_rd;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    state_t                state;
    state_t                state_nxt;
    logic [TS_WIDTH-1:0]   head_ts;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  first_wait;
    logic                  at_time;
    logic                  late;
    logic                  issue;

    assign s_ready   = !fifo_full;
    assign fifo_push = s_valid && s_ready;
    assign fifo_wr   = '{ts: s_timestamp, data: s_data};
    assign at_time   = (counter >= head_ts);
    // Lateness is only judged on the first enabled WAIT cycle of each head.
    assign late      = (state == WAIT) && start && first_wait && (counter > head_ts);

    rtio_sync_fifo #(
        .WIDTH     ($bits(entry_t)),
        .DEPTH     (FIFO_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .push     (fifo_push),
        .push_dat (fifo_wr),
        .pop      (fifo_pop),
        .pop_dat  (fifo_rd),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (start) begin
`ifdef RTIO_SCHED_LATE_DROP_EN
                    if (late) begin
                        fifo_pop  = !fifo_empty;
                        state_nxt = fifo_empty ? IDLE : WAIT;
                    end else if (at_time) begin
                        issue     = 1'b1;
                        state_nxt = ISSUE;
                    end
`else
                    // A late head also satisfies at_time and goes out immediately.
                    if (at_time) begin
                        issue     = 1'b1;
                        state_nxt = ISSUE;
                    end
`endif
                end
            end
            ISSUE: begin
                if (m_ready) begin
                    fifo_pop  = !fifo_empty;
                    state_nxt = fifo_empty ? IDLE : WAIT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            head_ts     <= '0;
            head_data   <= '0;
            first_wait  <= 1'b0;
            m_valid     <= 1'b0;
            m_timestamp <= '0;
            m_data      <= '0;
        end else if (flush) begin
            state      <= IDLE;
            first_wait <= 1'b0;
            m_valid    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fifo_pop) begin
                head_ts    <= fifo_rd.ts;
                head_data  <= fifo_rd.data;
                first_wait <= 1'b1;
            end else if ((state == WAIT) && start) begin
                first_wait <= 1'b0;
            end
            if (issue) begin
                m_valid     <= 1'b1;
                m_timestamp <= head_ts;
                m_data      <= head_data;
            end else if ((state == ISSUE) && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Sticky; a same-cycle late detection beats the clear. Flush leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            underflow <= 1'b0;
        end else if (late && !flush) begin
            underflow <= 1'b1;
        end else if (underflow_clr) begin
            underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rtio_event_scheduler.sv
// Bench for rtio_event_scheduler: directed scenarios plus a randomized run scored against an
// event-level timing model; honours RTIO_SCHED_LATE_DROP_EN.
module tb_rtio_event_scheduler;
    import rtio_sched_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int N     = 1500;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [63:0]   counter = '0;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic [63:0]   s_timestamp = '0;
    logic [63:0]   s_data = '0;
    logic          s_ready;
    logic          m_valid;
    logic [63:0]   m_timestamp;
    logic [63:0]   m_data;
    logic          m_ready = 1'b0;
    logic [CW-1:0] fifo_count;
    logic          underflow;
    logic          underflow_clr = 1'b0;

    rtio_event_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .counter       (counter),
        .flush         (flush),
        .s_valid       (s_valid),
        .s_timestamp   (s_timestamp),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .m_valid       (m_valid),
        .m_timestamp   (m_timestamp),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .fifo_count    (fifo_count),
        .underflow     (underflow),
        .underflow_clr (underflow_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    bit cnt_run = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (cnt_run) counter = counter + 64'd1;
    endtask

    task automatic do_reset();
        cnt_run       = 1'b0;
        reset         = 1'b1;
        s_valid       = 1'b0;
        flush         = 1'b0;
        underflow_clr = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (m_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Scoreboard shared with the monitor during the randomized run.
    typedef struct {
        int     cyc;
        event_t ev;
    } exp_t;

    exp_t        exp_q[$];
    bit          mon_en = 1'b0;
    int          rcyc = 0;
    bit          prev_hold = 1'b0;
    int          rise = 0;
    exp_t        e;

    always @(negedge clk) begin
        if (mon_en) begin
            if (m_valid) begin
                if (!prev_hold) rise = rcyc;
                if (m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rand_unexpected_issue: got ts 0x%0h at cycle %0d, expected no event",
                                 m_timestamp, rcyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("rand_issue_cycle", 64'(rise), 64'(e.cyc));
                        check("rand_issue_ts", m_timestamp, e.ev.ts);
                        check("rand_issue_data", m_data, e.ev.data);
                    end
                end
            end
            prev_hold = m_valid && !m_ready;
        end
    end

    // Randomized-run stimulus tables and model state.
    logic [63:0] r_cnt [N];
    logic [63:0] r_ts  [N];
    logic [63:0] r_dat [N];
    bit          r_start [N];
    bit          r_rdy   [N];
    bit          r_push  [N];
    int          ev_p[$];
    logic [63:0] ev_ts[$];
    logic [63:0] ev_dat[$];

    bit          ok;
    bit          seen;
    bit          stable;
    bit          any_late;
    bit          drop;
    int          accepted;
    int          pc, nev, m_w, m_c, m_iss, m_h, m_free;
    logic [63:0] cval, lts, base;
    logic [63:0] rc_cnt[$];
    logic [63:0] rc_ts[$];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values and basic timing.
        do_reset();
        @(negedge clk);
        check("reset_m_valid", m_valid, 0);
        check("reset_m_ts", m_timestamp, 0);
        check("reset_m_data", m_data, 0);
        check("reset_fifo_count", fifo_count, 0);
        check("reset_underflow", underflow, 0);
        check("reset_s_ready", s_ready, 1);
        tick();
        counter = 0; cnt_run = 1; start = 1; m_ready = 1;
        s_valid = 1; s_timestamp = 100; s_data = 64'hA5;
        tick();
        s_valid = 0;
        wait_valid(300, ok);
        check("basic_valid_seen", ok, 1);
        check("basic_counter_at_valid", counter, 101);
        check("basic_m_ts", m_timestamp, 100);
        check("basic_m_data", m_data, 64'hA5);
        check("basic_underflow", underflow, 0);
        tick();
        @(negedge clk);
        check("basic_valid_drop", m_valid, 0);

        // Back-to-back ordering; the second and third heads arrive late.
        do_reset();
        counter = 40; cnt_run = 1; start = 1; m_ready = 1;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1; s_timestamp = 64'(50 + i); s_data = 64'(16 + i);
            tick();
        end
        s_valid = 0;
        @(negedge clk);
        check("order_fifo_count", fifo_count, 2);
        tick();
        rc_cnt.delete(); rc_ts.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid) begin
                rc_cnt.push_back(counter);
                rc_ts.push_back(m_timestamp);
            end
            tick();
        end
`ifdef RTIO_SCHED_LATE_DROP_EN
        check("order_issue_count", rc_cnt.size(), 1);
        if (rc_cnt.size() >= 1) begin
            check("order_cnt0", rc_cnt[0], 51);
            check("order_ts0", rc_ts[0], 50);
        end
`else
        check("order_issue_count", rc_cnt.size(), 3);
        for (int i = 0; i < 3 && i < rc_cnt.size(); i++) begin
            check("order_cnt", rc_cnt[i], 64'(51 + 2 * i));
            check("order_ts", rc_ts[i], 64'(50 + i));
        end
`endif
        @(negedge clk);
        check("order_underflow", underflow, 1);
        check("order_fifo_empty", fifo_count, 0);
        tick();

        // Late event with clear held high: the set wins, then the clear takes effect.
        do_reset();
        counter = 200; start = 1; m_ready = 1; underflow_clr = 1;
        s_valid = 1; s_timestamp = 150; s_data = 64'h150;
        tick();
        s_valid = 0;
        tick();
        @(negedge clk);
        check("late_before_detect", underflow, 0);
        tick();
        @(negedge clk);
        check("late_underflow_set", underflow, 1);
`ifdef RTIO_SCHED_LATE_DROP_EN
        check("late_dropped_no_valid", m_valid, 0);
`else
        check("late_issued_valid", m_valid, 1);
        check("late_issued_ts", m_timestamp, 150);
`endif
        tick();
        @(negedge clk);
        check("late_underflow_cleared", underflow, 0);
        underflow_clr = 0;

        // Full FIFO: one head plus DEPTH entries.
        do_reset();
        counter = 0; start = 0; m_ready = 0; accepted = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            s_valid = 1; s_timestamp = 10; s_data = 64'(i);
            @(negedge clk);
            if (s_valid && s_ready) accepted++;
            tick();
        end
        s_valid = 0;
        @(negedge clk);
        check("full_accepted", accepted, DEPTH + 1);
        check("full_s_ready", s_ready, 0);
        check("full_fifo_count", fifo_count, DEPTH);
        check("full_no_valid", m_valid, 0);
        tick();

        // Start gating, then back-pressure with the counter running.
        do_reset();
        counter = 300; start = 0; m_ready = 0;
        s_valid = 1; s_timestamp = 300; s_data = 64'hC0FFEE;
        tick();
        s_valid = 0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen |= m_valid;
            tick();
        end
        check("gate_no_valid", seen, 0);
        start = 1;
        tick();
        @(negedge clk);
        check("gate_valid", m_valid, 1);
        check("gate_ts", m_timestamp, 300);
        check("gate_data", m_data, 64'hC0FFEE);
        cnt_run = 1;
        stable = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clk);
            stable &= m_valid && (m_timestamp == 64'd300) && (m_data == 64'hC0FFEE);
        end
        check("hold_stable", stable, 1);
        check("hold_underflow", underflow, 0);
        tick();
        m_ready = 1;
        tick();
        @(negedge clk);
        check("hold_released", m_valid, 0);

        // Flush mid-ISSUE keeps underflow.
        do_reset();
        counter = 500; start = 1; m_ready = 0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1; s_data = 64'(i + 1);
            s_timestamp = (i == 0) ? 64'd400 : (i == 1) ? 64'd500 : 64'd700;
            tick();
        end
        s_valid = 0;
        wait_valid(20, ok);
        check("flush_valid_seen", ok, 1);
        check("flush_pre_underflow", underflow, 1);
`ifdef RTIO_SCHED_LATE_DROP_EN
        check("flush_pre_ts", m_timestamp, 500);
        check("flush_pre_count", fifo_count, 1);
`else
        check("flush_pre_ts", m_timestamp, 400);
        check("flush_pre_count", fifo_count, 2);
`endif
        tick();
        flush = 1;
        tick();
        flush = 0;
        @(negedge clk);
        check("flush_m_valid", m_valid, 0);
        check("flush_fifo_count", fifo_count, 0);
        check("flush_s_ready", s_ready, 1);
        check("flush_keeps_underflow", underflow, 1);
        counter = 800;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            seen |= m_valid;
        end
        check("flush_discarded", seen, 0);
        tick();

        // Reset mid-ISSUE.
        do_reset();
        counter = 500; start = 1; m_ready = 0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1; s_data = 64'(i + 1);
            s_timestamp = (i == 0) ? 64'd400 : (i == 1) ? 64'd500 : 64'd700;
            tick();
        end
        s_valid = 0;
        wait_valid(20, ok);
        check("rst_valid_seen", ok, 1);
        check("rst_pre_underflow", underflow, 1);
        tick();
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_ts", m_timestamp, 0);
        check("rst_m_data", m_data, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_underflow", underflow, 0);
        check("rst_s_ready", s_ready, 1);
        counter = 800;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            seen |= m_valid;
        end
        check("rst_discarded", seen, 0);
        tick();

        // Randomized run: build per-cycle tables, then predict each event's issue cycle.
        cval = 1000;
        for (int c = 0; c < N; c++) begin
            r_start[c] = (c >= N - 300) ? 1'b1 : ($urandom_range(0, 7) != 0);
            r_rdy[c]   = (c >= N - 300) ? 1'b1 : ($urandom_range(0, 2) != 0);
            r_cnt[c]   = cval;
            r_push[c]  = 1'b0;
            r_ts[c]    = '0;
            r_dat[c]   = '0;
            if (r_start[c]) cval = cval + 64'd1;
        end
        pc = 5; nev = 0; lts = 0;
        while (nev < 14 && pc < N - 400) begin
            base = r_cnt[pc] + 64'($urandom_range(0, 60)) - 64'd20;
            if (base < lts) base = lts;
            lts = base;
            r_push[pc] = 1'b1;
            r_ts[pc]   = base;
            r_dat[pc]  = {$urandom, $urandom};
            ev_p.push_back(pc);
            ev_ts.push_back(base);
            ev_dat.push_back(r_dat[pc]);
            nev++;
            pc += $urandom_range(1, 45);
        end
        m_free = 0; any_late = 0;
        for (int k = 0; k < ev_p.size(); k++) begin
            m_w = (ev_p[k] + 2 > m_free) ? ev_p[k] + 2 : m_free;
            m_c = m_w;
            drop = 0;
            while (m_c < N - 1 && !r_start[m_c]) m_c++;
            if (r_cnt[m_c] > ev_ts[k]) begin
                any_late = 1;
`ifdef RTIO_SCHED_LATE_DROP_EN
                drop = 1;
`endif
            end else begin
                while (m_c < N - 1 && !(r_start[m_c] && r_cnt[m_c] >= ev_ts[k])) m_c++;
            end
            if (drop) begin
                m_free = m_c + 1;
            end else begin
                m_iss = m_c + 1;
                m_h = m_iss;
                while (m_h < N - 1 && !r_rdy[m_h]) m_h++;
                m_free = m_h + 1;
                exp_q.push_back('{cyc: m_iss, ev: '{ts: ev_ts[k], data: ev_dat[k]}});
            end
        end

        reset = 1; cnt_run = 0; s_valid = 0;
        for (int c = 0; c < N; c++) begin
            tick();
            reset       = 1'b0;
            rcyc        = c;
            counter     = r_cnt[c];
            start       = r_start[c];
            m_ready     = r_rdy[c];
            s_valid     = r_push[c];
            s_timestamp = r_ts[c];
            s_data      = r_dat[c];
            if (c == 0) begin
                prev_hold = 1'b0;
                mon_en    = 1'b1;
            end
        end
        tick();
        mon_en = 1'b0;
        s_valid = 0;
        check("rand_all_issued", exp_q.size(), 0);
        check("rand_underflow", underflow, any_late);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
